pipe_ctrl_sequencer: RTL

//  Pipelined successor of the combinational control unit. Decodes instruction_type/func in ID and

---
 rtl/pipe_ctrl_pkg.sv | 52 +++++
 rtl/ctrl_decoder.sv | 100 ++++++++++
 rtl/pipe_ctrl_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipelined control sequencer: control bundle, encodings, FSM states.
// Optional perf counters in the top are enabled with CTRL_PERF_CNT_EN.
package pipe_ctrl_pkg;

   // Spare MSB keeps the registered bundle at 19 bits; it is always 0.
   typedef struct packed {
      logic       rsvd;
      logic       JumpI;
      logic       JumpCI;
      logic       JumpCD;
      logic       MemToReg;
      logic       MemRead;
      logic       MemWrite;
      logic [2:0] ALUOp;
      logic       ALUSrc;
      logic       RegWrite;
      logic [1:0] ImmSrc;
      logic [1:0] RegDtn;
      logic       RegSrc2;
      logic [1:0] RegSrc1;
   } ctrl_t;

   localparam logic [1:0] ITYPE_CTRL = 2'b00;
   localparam logic [1:0] ITYPE_MEM  = 2'b01;
   localparam logic [1:0] ITYPE_DATA = 2'b10;

   localparam logic [1:0] FMT_REG = 2'b00;
   localparam logic [1:0] FMT_IMM = 2'b11;

   localparam logic [4:0] FUNC_SI  = 5'b00000;
   localparam logic [4:0] FUNC_SCI = 5'b00010;
   localparam logic [4:0] FUNC_SCD = 5'b00011;
   localparam logic [4:0] FUNC_GDR = 5'b00000;
   localparam logic [4:0] FUNC_CRG = 5'b00001;

   localparam logic [2:0] ALU_SUM = 3'b000;
   localparam logic [2:0] ALU_RES = 3'b001;
   localparam logic [2:0] ALU_MUL = 3'b010;
   localparam logic [2:0] ALU_DIV = 3'b011;
   localparam logic [2:0] ALU_RSD = 3'b100;

   localparam logic [1:0] IMM_DATA = 2'b00;
   localparam logic [1:0] IMM_MEM  = 2'b01;
   localparam logic [1:0] IMM_JUMP = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_MC_BUSY = 2'b01,
      ST_BUBBLE  = 2'b10
   } state_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational ID-stage decode of instruction_type/func into the control bundle,
// plus illegal flag, source-register usage and multi-cycle op flags.
module ctrl_decoder
   import pipe_ctrl_pkg::*;
(
   input  logic [1:0] instruction_type,
   input  logic [4:0] func,
   output ctrl_t      ctrl,
   output logic       illegal,
   output logic       uses_rs1,
   output logic       uses_rs2,
   output logic       is_mul,
   output logic       is_div
);

   logic       fmt_ok;
   logic       alu_ok;
   logic       is_imm;

   assign is_imm = (func[4:3] == FMT_IMM);
   assign fmt_ok = (func[4:3] == FMT_REG) || is_imm;
   assign alu_ok = func[2:0] inside {ALU_SUM, ALU_RES, ALU_MUL, ALU_DIV, ALU_RSD};

   always_comb begin
      ctrl     = '0;
      illegal  = 1'b1;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      is_mul   = 1'b0;
      is_div   = 1'b0;
      case (instruction_type)
         ITYPE_DATA: begin
            if (fmt_ok && alu_ok) begin
               illegal       = 1'b0;
               ctrl.ALUOp    = func[2:0];
               ctrl.RegWrite = 1'b1;
               uses_rs1      = 1'b1;
               is_mul        = (func[2:0] == ALU_MUL);
               is_div        = (func[2:0] == ALU_DIV);
               if (is_imm) begin
                  ctrl.ALUSrc = 1'b1;
                  ctrl.ImmSrc = IMM_DATA;
               end else begin
                  uses_rs2 = 1'b1;
               end
            end
         end
         ITYPE_CTRL: begin
            case (func)
               FUNC_SI: begin
                  illegal     = 1'b0;
                  ctrl.JumpI  = 1'b1;
                  ctrl.ImmSrc = IMM_JUMP;
               end
               // Conditional jumps compare two registers.
               FUNC_SCI: begin
                  illegal     = 1'b0;
                  ctrl.JumpCI = 1'b1;
                  ctrl.ImmSrc = IMM_JUMP;
                  uses_rs1    = 1'b1;
                  uses_rs2    = 1'b1;
               end
               FUNC_SCD: begin
                  illegal     = 1'b0;
                  ctrl.JumpCD = 1'b1;
                  ctrl.ImmSrc = IMM_JUMP;
                  uses_rs1    = 1'b1;
                  uses_rs2    = 1'b1;
               end
               default: ;
            endcase
         end
         ITYPE_MEM: begin
            case (func)
               FUNC_GDR: begin
                  illegal       = 1'b0;
                  ctrl.MemWrite = 1'b1;
                  ctrl.ALUSrc   = 1'b1;
                  ctrl.ImmSrc   = IMM_MEM;
                  ctrl.RegSrc2  = 1'b1;
                  uses_rs1      = 1'b1;
                  uses_rs2      = 1'b1;
               end
               FUNC_CRG: begin
                  illegal       = 1'b0;
                  ctrl.MemRead  = 1'b1;
                  ctrl.MemToReg = 1'b1;
                  ctrl.RegWrite = 1'b1;
                  ctrl.ALUSrc   = 1'b1;
                  ctrl.ImmSrc   = IMM_MEM;
                  uses_rs1      = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// ID-stage decode registered into ID/EX, with MUL/DIV holds, load-use bubbles and branch flushes.
// Define CTRL_PERF_CNT_EN to add saturating stall/flush counters and their ports.
module pipe_ctrl_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW     = 4,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 8,
   parameter int PERF_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [1:0]        instruction_type,
   input  logic [4:0]        func,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              branch_taken,
   output logic              ex_valid,
   output ctrl_t             ex_ctrl,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_busy,
   output logic              illegal_op
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
`endif
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   if (MUL_CYCLES < 1 || DIV_CYCLES < 1 || REG_AW < 1 || PERF_W < 1) begin : g_param_err
      $error("pipe_ctrl_sequencer: parameters out of range");
   end

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              ex_valid_n;
   ctrl_t             ex_ctrl_n;
   logic [REG_AW-1:0] ex_rd_n;
   logic              illegal_n;

   ctrl_t             dec_ctrl;
   logic              dec_illegal;
   logic              dec_rs1;
   logic              dec_rs2;
   logic              dec_mul;
   logic              dec_div;
   logic              load_use;

   ctrl_decoder u_dec (
      .instruction_type (instruction_type),
      .func             (func),
      .ctrl             (dec_ctrl),
      .illegal          (dec_illegal),
      .uses_rs1         (dec_rs1),
      .uses_rs2         (dec_rs2),
      .is_mul           (dec_mul),
      .is_div           (dec_div)
   );

   // A load in EX whose result the ID op needs cannot forward in time.
   assign load_use = ex_valid && ex_ctrl.MemRead && id_valid &&
                     ((dec_rs1 && (ex_rd == id_rs1)) || (dec_rs2 && (ex_rd == id_rs2)));

   assign ex_busy = (state == ST_MC_BUSY);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      id_ready   = 1'b0;
      ex_valid_n = 1'b0;
      ex_ctrl_n  = '0;
      ex_rd_n    = '0;
      illegal_n  = 1'b0;
      if (branch_taken) begin
         id_ready = 1'b1;
         cnt_n    = '0;
         state_n  = ST_RUN;
      end else if (state == ST_MC_BUSY) begin
         ex_valid_n = ex_valid;
         ex_ctrl_n  = ex_ctrl;
         ex_rd_n    = ex_rd;
         cnt_n      = cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            state_n = ST_RUN;
         end
      end else if (load_use) begin
         state_n = ST_BUBBLE;
      end else begin
         // RUN, and BUBBLE which re-evaluates the held ID op exactly like RUN.
         id_ready = 1'b1;
         state_n  = ST_RUN;
         if (id_valid) begin
            illegal_n = dec_illegal;
            if (!dec_illegal) begin
               ex_valid_n = 1'b1;
               ex_ctrl_n  = dec_ctrl;
               ex_rd_n    = id_rd;
               if (dec_mul && (MUL_CYCLES > 1)) begin
                  cnt_n   = CNT_W'(MUL_CYCLES - 1);
                  state_n = ST_MC_BUSY;
               end else if (dec_div && (DIV_CYCLES > 1)) begin
                  cnt_n   = CNT_W'(DIV_CYCLES - 1);
                  state_n = ST_MC_BUSY;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_RUN;
         cnt        <= '0;
         ex_valid   <= 1'b0;
         ex_ctrl    <= '0;
         ex_rd      <= '0;
         illegal_op <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         ex_valid   <= ex_valid_n;
         ex_ctrl    <= ex_ctrl_n;
         ex_rd      <= ex_rd_n;
         illegal_op <= illegal_n;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (id_valid && !id_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
         end
         if (branch_taken && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + PERF_W'(1);
         end
      end
   end
`endif

endmodule
